// File: rtl/debounce_edge_det.sv
// Debounces a synchronized level and emits registered one-cycle rise/fall pulses plus a saturating rise count.
// Latency: output changes on the (STABLE_CYCLES-1)th edge after the first edge that samples the new level.
// Backpressure: none; sync_in may change every cycle, all outputs are plain registers.
module debounce_edge_det #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3,
    parameter int EVT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_in,
    input  logic                 clear_evt,
    output logic                 clean_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [EVT_WIDTH-1:0] rise_count
);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_TO_HIGH = 2'd1,
        ST_HIGH    = 2'd2,
        ST_TO_LOW  = 2'd3
    } state_t;

    // Counter value at which the next matching sample completes a transition.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    // A single stable sample is enough: skip the TO_* states entirely.
    localparam bit                   DIRECT   = (STABLE_CYCLES == 1);
    localparam logic [EVT_WIDTH-1:0] EVT_MAX  = '1;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   clean_out_q, clean_out_d;
    logic                   rise_pulse_q, rise_pulse_d;
    logic                   fall_pulse_q, fall_pulse_d;
    logic [EVT_WIDTH-1:0]   rise_count_q, rise_count_d;

    // State and stability counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: count consecutive new-level samples, abort on any old-level sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (sync_in) begin
                    if (DIRECT) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_TO_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_TO_HIGH: begin
                if (!sync_in) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_in) begin
                    if (DIRECT) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_TO_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_TO_LOW: begin
                if (sync_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the transition being taken; clear wins over a same-edge increment.
    always_comb begin
        clean_out_d  = (state_d == ST_HIGH) || (state_d == ST_TO_LOW);
        rise_pulse_d = ((state_q == ST_LOW) || (state_q == ST_TO_HIGH)) && (state_d == ST_HIGH);
        fall_pulse_d = ((state_q == ST_HIGH) || (state_q == ST_TO_LOW)) && (state_d == ST_LOW);
        rise_count_d = rise_count_q;
        if (clear_evt) begin
            rise_count_d = '0;
        end else if (rise_pulse_d && (rise_count_q != EVT_MAX)) begin
            rise_count_d = rise_count_q + 1'b1;
        end
    end

    // Output register; reset drops everything without generating a fall pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            clean_out_q  <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            rise_count_q <= '0;
        end else begin
            clean_out_q  <= clean_out_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            rise_count_q <= rise_count_d;
        end
    end

    assign clean_out  = clean_out_q;
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
    assign rise_count = rise_count_q;

endmodule
